// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM state encoding,
// PC-select codes and counter widths.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_DIVW = 2'd1,
        ST_EXCF = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEQ  = 2'd0;
    localparam logic [1:0] PC_BR   = 2'd1;
    localparam logic [1:0] PC_EXC  = 2'd2;
    localparam logic [1:0] PC_ERTN = 2'd3;

    // Wide enough for the largest legal divider stall count (255)
    localparam int DIVCNT_W = 8;
    localparam int PERF_W   = 32;

    // An exception wins over an ertn that commits in the same cycle
    function automatic logic [1:0] trap_pc_sel(input logic exc);
        return exc ? PC_EXC : PC_ERTN;
    endfunction

endpackage

// File: rtl/pipe_ctrl_divcnt.sv
// Divider stall down-counter: loads a cycle count and counts down to zero.
module pipe_ctrl_divcnt
    import pipe_ctrl_pkg::*;
#(
    parameter int W = DIVCNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= value;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/flush controller with divider stall sequencing.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 16,
    parameter int RFIDX_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RFIDX_W-1:0] rs1D,
    input  logic [RFIDX_W-1:0] rs2D,
    input  logic [RFIDX_W-1:0] rdE,
    input  logic               memtoregE,
    input  logic               branch_mispE,
    input  logic               div_startE,
    input  logic               excM,
    input  logic               ertnM,
    input  logic               imem_wait,
    output logic               enF,
    output logic               enD,
    output logic               enE,
    output logic               flushD,
    output logic               flushE,
    output logic               flushM,
    output logic               flushW,
    output logic [1:0]         pc_sel,
    output logic               div_done,
    output logic               div_abort,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
);

    localparam logic [DIVCNT_W-1:0] DIV_LOAD = DIVCNT_W'(DIV_CYCLES - 1);

    state_t state_reg, state_next;
    logic   div_load, div_dec, div_zero;
    logic   trap, load_use;

    assign trap     = excM | ertnM;
    assign load_use = memtoregE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

    pipe_ctrl_divcnt #(
        .W (DIVCNT_W)
    ) u_divcnt (
        .clk   (clk),
        .reset (reset),
        .load  (div_load),
        .value (DIV_LOAD),
        .dec   (div_dec),
        .zero  (div_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // A mispredict outranks the divider, so a divide in progress simply
    // holds its place for that cycle.
    always_comb begin
        state_next = state_reg;
        if (trap) begin
            state_next = ST_EXCF;
        end else if (branch_mispE) begin
            if (state_reg == ST_EXCF) begin
                state_next = ST_RUN;
            end
        end else begin
            case (state_reg)
                ST_RUN:  if (div_startE) state_next = ST_DIVW;
                ST_DIVW: if (div_zero) state_next = ST_RUN;
                ST_EXCF: state_next = ST_RUN;
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_comb begin
        enF       = 1'b1;
        enD       = 1'b1;
        enE       = 1'b1;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushM    = 1'b0;
        flushW    = 1'b0;
        pc_sel    = PC_SEQ;
        div_done  = 1'b0;
        div_abort = 1'b0;
        div_load  = 1'b0;
        div_dec   = 1'b0;
        if (!reset) begin
            // The cycle after a trap also squashes whatever was fetched into ID
            if (state_reg == ST_EXCF) begin
                flushD = 1'b1;
            end
            if (trap) begin
                flushD    = 1'b1;
                flushE    = 1'b1;
                flushM    = 1'b1;
                flushW    = 1'b1;
                pc_sel    = trap_pc_sel(excM);
                div_abort = (state_reg == ST_DIVW);
            end else if (branch_mispE) begin
                flushD = 1'b1;
                flushE = 1'b1;
                pc_sel = PC_BR;
            end else if ((state_reg == ST_RUN) && div_startE) begin
                enF      = 1'b0;
                enD      = 1'b0;
                enE      = 1'b0;
                div_load = 1'b1;
            end else if ((state_reg == ST_DIVW) && !div_zero) begin
                enF     = 1'b0;
                enD     = 1'b0;
                enE     = 1'b0;
                flushM  = 1'b1;
                div_dec = 1'b1;
            end else begin
                // On the completion cycle the front end may still stall
                div_done = (state_reg == ST_DIVW);
                if (load_use || imem_wait) begin
                    enF    = 1'b0;
                    enD    = 1'b0;
                    flushE = 1'b1;
                end
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [1:0]             perf_inc;
    logic [1:0][PERF_W-1:0] perf_cnt;

    assign perf_inc = {flushD | flushE, ~enD};

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        logic [PERF_W-1:0] cnt_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_reg <= '0;
            end else if (perf_inc[gi]) begin
                cnt_reg <= cnt_reg + PERF_W'(1);
            end
        end

        assign perf_cnt[gi] = cnt_reg;
    end

    assign stall_cnt = perf_cnt[0];
    assign flush_cnt = perf_cnt[1];
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int DIV = 16;
    localparam int RW  = 5;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] rs1D, rs2D, rdE;
    logic          memtoregE, branch_mispE, div_startE, excM, ertnM, imem_wait;
    logic          enF, enD, enE, flushD, flushE, flushM, flushW;
    logic [1:0]    pc_sel;
    logic          div_done, div_abort;
    logic [31:0]   stall_cnt, flush_cnt;
    logic [10:0]   outv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .DIV_CYCLES (DIV),
        .RFIDX_W    (RW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rs1D         (rs1D),
        .rs2D         (rs2D),
        .rdE          (rdE),
        .memtoregE    (memtoregE),
        .branch_mispE (branch_mispE),
        .div_startE   (div_startE),
        .excM         (excM),
        .ertnM        (ertnM),
        .imem_wait    (imem_wait),
        .enF          (enF),
        .enD          (enD),
        .enE          (enE),
        .flushD       (flushD),
        .flushE       (flushE),
        .flushM       (flushM),
        .flushW       (flushW),
        .pc_sel       (pc_sel),
        .div_done     (div_done),
        .div_abort    (div_abort),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    assign outv = {enF, enD, enE, flushD, flushE, flushM, flushW, pc_sel, div_done, div_abort};

    function automatic logic [10:0] mk(input logic ef, ed, ee, fd, fe, fm, fw,
                                       input logic [1:0] pc, input logic done, abort);
        return {ef, ed, ee, fd, fe, fm, fw, pc, done, abort};
    endfunction

    localparam logic [10:0] IDLE_V = 11'b111_0000_00_0_0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1D = '0; rs2D = '0; rdE = '0;
        memtoregE = 0; branch_mispE = 0; div_startE = 0;
        excM = 0; ertnM = 0; imem_wait = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        excM = 1; imem_wait = 1; div_startE = 1; branch_mispE = 1;
        reset = 1'b1;
        #2;
        n_checks++;
        if (outv !== IDLE_V) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", outv, IDLE_V);
        end
        tick();
        n_checks++;
        if (outv !== IDLE_V || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_hold: got %b/%0d/%0d expected %b/0/0", outv, stall_cnt, flush_cnt, IDLE_V);
        end
        idle();
        reset = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_load_use();
        logic [10:0] e;
        memtoregE = 1; rdE = 5; rs2D = 5; rs1D = 3;
        #1;
        e = mk(0, 0, 1, 0, 1, 0, 0, 2'd0, 0, 0);
        n_checks++;
        if (outv !== e) begin n_fail++; $display("FAIL load_use_rs2: got %b expected %b", outv, e); end
        tick();
        rdE = 0; rs2D = 0; rs1D = 0;
        #1;
        n_checks++;
        if (outv !== IDLE_V) begin n_fail++; $display("FAIL load_use_rd0: got %b expected %b", outv, IDLE_V); end
        tick();
        rdE = 7; rs1D = 7; rs2D = 1; memtoregE = 0;
        #1;
        n_checks++;
        if (outv !== IDLE_V) begin n_fail++; $display("FAIL load_use_noload: got %b expected %b", outv, IDLE_V); end
        tick();
        memtoregE = 1;
        #1;
        n_checks++;
        if (outv !== e) begin n_fail++; $display("FAIL load_use_rs1: got %b expected %b", outv, e); end
        tick();
        idle();
        $display("test_load_use done");
    endtask

    task automatic test_divide();
        logic [10:0] e;
        div_startE = 1;
        for (int i = 0; i <= DIV; i++) begin
            #1;
            if (i < DIV) e = mk(0, 0, 0, 0, 0, (i > 0), 0, 2'd0, 0, 0);
            else         e = mk(1, 1, 1, 0, 0, 0, 0, 2'd0, 1, 0);
            n_checks++;
            if (outv !== e) begin n_fail++; $display("FAIL divide_cycle%0d: got %b expected %b", i, outv, e); end
            if (i == DIV) div_startE = 0;
            tick();
        end
        #1;
        n_checks++;
        if (outv !== IDLE_V) begin n_fail++; $display("FAIL divide_after: got %b expected %b", outv, IDLE_V); end
        tick();
        $display("test_divide done");
    endtask

    task automatic test_exc_mid_div();
        logic [10:0] e;
        div_startE = 1;
        for (int i = 0; i < 5; i++) tick();
        div_startE = 0; excM = 1;
        #1;
        e = mk(1, 1, 1, 1, 1, 1, 1, 2'd2, 0, 1);
        n_checks++;
        if (outv !== e) begin n_fail++; $display("FAIL exc_mid_div: got %b expected %b", outv, e); end
        tick();
        excM = 0;
        #1;
        e = mk(1, 1, 1, 1, 0, 0, 0, 2'd0, 0, 0);
        n_checks++;
        if (outv !== e) begin n_fail++; $display("FAIL exc_excf: got %b expected %b", outv, e); end
        tick();
        for (int i = 0; i < 20; i++) begin
            #1;
            n_checks++;
            if (outv !== IDLE_V) begin n_fail++; $display("FAIL exc_no_done%0d: got %b expected %b", i, outv, IDLE_V); end
            tick();
        end
        $display("test_exc_mid_div done");
    endtask

    task automatic test_simultaneous();
        logic [10:0] e;
        branch_mispE = 1; memtoregE = 1; rdE = 9; rs1D = 9;
        #1;
        e = mk(1, 1, 1, 1, 1, 0, 0, 2'd1, 0, 0);
        n_checks++;
        if (outv !== e) begin n_fail++; $display("FAIL misp_plus_load_use: got %b expected %b", outv, e); end
        tick();
        idle();
        $display("test_simultaneous done");
    endtask

    task automatic test_ertn();
        logic [10:0] e;
        ertnM = 1;
        #1;
        e = mk(1, 1, 1, 1, 1, 1, 1, 2'd3, 0, 0);
        n_checks++;
        if (outv !== e) begin n_fail++; $display("FAIL ertn_cycle: got %b expected %b", outv, e); end
        tick();
        ertnM = 0;
        #1;
        e = mk(1, 1, 1, 1, 0, 0, 0, 2'd0, 0, 0);
        n_checks++;
        if (outv !== e) begin n_fail++; $display("FAIL ertn_excf: got %b expected %b", outv, e); end
        tick();
        #1;
        n_checks++;
        if (outv !== IDLE_V) begin n_fail++; $display("FAIL ertn_return: got %b expected %b", outv, IDLE_V); end
        tick();
        $display("test_ertn done");
    endtask

    task automatic test_div_reset();
        div_startE = 1;
        tick(); tick(); tick();
        div_startE = 0;
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (outv !== IDLE_V) begin n_fail++; $display("FAIL div_reset_during: got %b expected %b", outv, IDLE_V); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_checks++;
            if (outv !== IDLE_V) begin n_fail++; $display("FAIL div_reset_after%0d: got %b expected %b", i, outv, IDLE_V); end
            tick();
        end
        $display("test_div_reset done");
    endtask

    task automatic test_perf();
        logic [10:0] e;
        logic [31:0] exp3;
        do_reset();
        imem_wait = 1;
        e = mk(0, 0, 1, 0, 1, 0, 0, 2'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (outv !== e) begin n_fail++; $display("FAIL imem_wait%0d: got %b expected %b", i, outv, e); end
            tick();
        end
        imem_wait = 0;
        #1;
        exp3 = PERF ? 32'd3 : 32'd0;
        n_checks++;
        if (stall_cnt !== exp3 || flush_cnt !== exp3) begin
            n_fail++; $display("FAIL perf_counts: got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt, exp3, exp3);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_fail++; $display("FAIL perf_async_reset: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        reset = 1'b0;
        tick();
        $display("test_perf done");
    endtask

    // Behavioural model: div_left counts remaining stall cycles of an active
    // divide (-1 when none); excf marks the post-trap flush cycle.
    int          m_div_left;
    bit          m_excf;
    int unsigned m_stall, m_flush;

    task automatic model_step(output logic [10:0] e);
        logic ef, ed, ee, fd, fe, fm, fw, done, abort;
        logic [1:0] pc;
        bit busy;
        busy = (m_div_left >= 0);
        ef = 1; ed = 1; ee = 1; fd = m_excf; fe = 0; fm = 0; fw = 0;
        pc = 2'd0; done = 0; abort = 0;
        if (excM || ertnM) begin
            fd = 1; fe = 1; fm = 1; fw = 1;
            pc = excM ? 2'd2 : 2'd3;
            abort = busy;
            m_div_left = -1;
            m_excf = 1;
        end else begin
            if (branch_mispE) begin
                fd = 1; fe = 1; pc = 2'd1;
            end else if (!busy && !m_excf && div_startE) begin
                ef = 0; ed = 0; ee = 0;
                m_div_left = DIV - 1;
            end else if (busy && m_div_left > 0) begin
                ef = 0; ed = 0; ee = 0; fm = 1;
                m_div_left--;
            end else begin
                if (busy) begin
                    done = 1;
                    m_div_left = -1;
                end
                if ((memtoregE && rdE != 0 && (rdE == rs1D || rdE == rs2D)) || imem_wait) begin
                    ef = 0; ed = 0; fe = 1;
                end
            end
            m_excf = 0;
        end
        if (!ed) m_stall++;
        if (fd || fe) m_flush++;
        e = mk(ef, ed, ee, fd, fe, fm, fw, pc, done, abort);
    endtask

    task automatic test_random();
        logic [10:0] e;
        logic [31:0] es, ef;
        do_reset();
        m_div_left = -1; m_excf = 0; m_stall = 0; m_flush = 0;
        for (int c = 0; c < 3000; c++) begin
            excM         = ($urandom_range(0, 39) == 0);
            ertnM        = ($urandom_range(0, 39) == 0);
            branch_mispE = ($urandom_range(0, 15) == 0);
            div_startE   = ($urandom_range(0, 5) == 0);
            imem_wait    = ($urandom_range(0, 3) == 0);
            memtoregE    = $urandom_range(0, 1);
            rdE          = RW'($urandom_range(0, 7));
            rs1D         = RW'($urandom_range(0, 7));
            rs2D         = RW'($urandom_range(0, 7));
            #1;
            es = PERF ? m_stall : 32'd0;
            ef = PERF ? m_flush : 32'd0;
            n_checks++;
            if (stall_cnt !== es || flush_cnt !== ef) begin
                n_fail++; $display("FAIL rand_counters c%0d: got %0d/%0d expected %0d/%0d", c, stall_cnt, flush_cnt, es, ef);
            end
            model_step(e);
            n_checks++;
            if (outv !== e) begin
                n_fail++; $display("FAIL rand_outputs c%0d: got %b expected %b", c, outv, e);
            end
            tick();
        end
        idle();
        $display("test_random done");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b0;
        #1;
        test_reset();
        test_load_use();
        test_divide();
        test_exc_mid_div();
        test_simultaneous();
        test_ertn();
        test_div_reset();
        test_perf();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
